// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - circular-buffer capture with level/edge trigger and 512-sample readout
module capture_ctrl #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          rclk,
    input  logic          rst,
    input  logic [7:0]    adc_data,
    input  logic          smpl_en,
    input  logic          arm,
    input  logic [7:0]    trig_lvl,
    input  logic          trig_edge,
    input  logic [AW-1:0] trig_pos,
    input  logic          dump_req,
    input  logic          dump_rdy,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic [7:0]    dump_data,
    output logic          dump_vld,
    output logic          capture_done,
    output logic          busy,
    output logic [AW-1:0] trig_addr
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DONE,
        DRD,
        DOUT
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] fill;
    logic [AW-1:0] post_cnt;
    logic [7:0]    prev;
    logic          prev_vld;

    logic          capturing;
    logic          arm_ok;
    logic          wr_stb;
    logic          trig_hit;

    // An arm in the same cycle as a strobe restarts the buffer, so that sample is dropped
    assign capturing = (state == FILL) || (state == ARMED) || (state == POST);
    assign arm_ok    = arm && (state != DRD) && (state != DOUT);
    assign wr_stb    = capturing && smpl_en && !arm;
    assign dump_data = ram_rdata;

    // Crossing detector between the previous and current sample
    always_comb begin
        trig_hit = 1'b0;
        if (prev_vld) begin
            if (trig_edge)
                trig_hit = (prev < trig_lvl) && (adc_data >= trig_lvl);
            else
                trig_hit = (prev > trig_lvl) && (adc_data <= trig_lvl);
        end
    end

    // RAM port: sample writes during capture, single read issue in DRD, idle otherwise
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (wr_stb) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_ptr;
            ram_wdata = adc_data;
        end else if (state == DRD) begin
            ram_en   = 1'b1;
            ram_addr = rd_ptr;
        end
    end

    // Capture/dump sequencer with registered status outputs
    always_ff @(posedge rclk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_cnt       <= '0;
            fill         <= '0;
            post_cnt     <= '0;
            prev         <= '0;
            prev_vld     <= 1'b0;
            trig_addr    <= '0;
            capture_done <= 1'b0;
            busy         <= 1'b0;
            dump_vld     <= 1'b0;
        end else if (arm_ok) begin
            state        <= FILL;
            wr_ptr       <= '0;
            fill         <= '0;
            prev_vld     <= 1'b0;
            capture_done <= 1'b0;
            busy         <= 1'b1;
            dump_vld     <= 1'b0;
        end else begin
            if (capturing && smpl_en) begin
                wr_ptr   <= wr_ptr + 1'b1;
                prev     <= adc_data;
                prev_vld <= 1'b1;
                if (fill != LAST)
                    fill <= fill + 1'b1;
            end
            case (state)
                FILL: begin
                    // Enough history so the post-trigger window fits in the buffer
                    if (fill >= LAST - trig_pos)
                        state <= ARMED;
                end
                ARMED: begin
                    if (smpl_en && trig_hit) begin
                        trig_addr <= wr_ptr;
                        post_cnt  <= trig_pos;
                        if (trig_pos == '0) begin
                            state        <= DONE;
                            capture_done <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            state <= POST;
                        end
                    end
                end
                POST: begin
                    if (smpl_en) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == AW'(1)) begin
                            state        <= DONE;
                            capture_done <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // wr_ptr already points one past the last write, i.e. the oldest sample
                    if (dump_req) begin
                        rd_ptr <= wr_ptr;
                        rd_cnt <= '0;
                        state  <= DRD;
                        busy   <= 1'b1;
                    end
                end
                DRD: begin
                    state    <= DOUT;
                    dump_vld <= 1'b1;
                end
                DOUT: begin
                    if (dump_rdy) begin
                        rd_ptr   <= rd_ptr + 1'b1;
                        rd_cnt   <= rd_cnt + 1'b1;
                        dump_vld <= 1'b0;
                        if (rd_cnt == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DRD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
